// File: rtl/data_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_arbiter
// Brief    : Shares the single-port data RAM between the CPU controller and
//            the host/debug port. CPU has fixed priority; the host may lock
//            the RAM for bounded bursts, after which it yields for one cycle.
//            Optional macro ARB_STARVE_GUARD_EN adds a starvation guard that
//            forces a host grant after MAX_WAIT consecutive blocked cycles.
// Revision : 1.0 - initial release
// ============================================================================
module data_ram_arbiter #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 8,
  parameter int MAX_WAIT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_q,
  output logic [1:0]        owner
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_YIELD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0] w_burst_cnt_nxt;
  logic [CNT_W-1:0] w_burst_inc;
  logic             w_cpu_gnt;
  logic             w_host_gnt;
  logic             w_cpu_acc;
  logic             w_host_acc;
  logic             w_force_host;
  logic             r_cpu_rvalid;
  logic             r_host_rvalid;

  assign w_cpu_acc   = cpu_req & w_cpu_gnt;
  assign w_host_acc  = host_req & w_host_gnt;
  assign w_burst_inc = r_burst_cnt + 1'b1;

`ifdef ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] r_wait_cnt;

  // Count consecutive IDLE cycles the host spends blocked; saturates at MAX_WAIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if (w_host_acc || !host_req) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ST_IDLE) && (r_wait_cnt != WAIT_W'(MAX_WAIT))) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign w_force_host = host_req & (r_wait_cnt == WAIT_W'(MAX_WAIT));
`else
  assign w_force_host = 1'b0;
`endif

  // State and burst counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  // Grant decode: at most one grant, all grants held low while in reset.
  always_comb begin
    w_cpu_gnt  = 1'b0;
    w_host_gnt = 1'b0;
    if (reset) begin
      case (r_state)
        ST_IDLE: begin
          if (cpu_req && !w_force_host) begin
            w_cpu_gnt = 1'b1;
          end else begin
            w_host_gnt = host_req;
          end
        end
        ST_BURST: w_host_gnt = host_req;
        ST_YIELD: w_cpu_gnt  = cpu_req;
        default:  ;
      endcase
    end
  end

  // Next-state logic: lock entry, burst counting, forced yield, unlock.
  always_comb begin
    w_state_nxt     = r_state;
    w_burst_cnt_nxt = r_burst_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_host_acc && host_lock) begin
          w_burst_cnt_nxt = CNT_W'(1);
          w_state_nxt     = (MAX_BURST == 1) ? ST_YIELD : ST_BURST;
        end
      end
      ST_BURST: begin
        if (!host_lock) begin
          w_state_nxt     = ST_IDLE;
          w_burst_cnt_nxt = '0;
        end else if (w_host_acc) begin
          w_burst_cnt_nxt = w_burst_inc;
          if (w_burst_inc == CNT_W'(MAX_BURST)) begin
            w_state_nxt = ST_YIELD;
          end
        end
      end
      ST_YIELD: begin
        w_state_nxt     = ST_IDLE;
        w_burst_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_burst_cnt_nxt = '0;
      end
    endcase
  end

  // RAM pin mux: granted port drives the RAM; idle defaults to a harmless read.
  always_comb begin
    ram_addr = cpu_addr;
    ram_data = '0;
    ram_en   = 1'b0;
    if (w_host_gnt) begin
      ram_addr = host_addr;
      ram_data = host_wdata;
      ram_en   = host_we;
    end else if (w_cpu_gnt) begin
      ram_data = cpu_wdata;
      ram_en   = cpu_we;
    end
  end

  // Read-valid flags: one cycle after an accepted read by each port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cpu_rvalid  <= 1'b0;
      r_host_rvalid <= 1'b0;
    end else begin
      r_cpu_rvalid  <= w_cpu_acc & ~cpu_we;
      r_host_rvalid <= w_host_acc & ~host_we;
    end
  end

  assign cpu_gnt     = w_cpu_gnt;
  assign host_gnt    = w_host_gnt;
  assign cpu_rvalid  = r_cpu_rvalid;
  assign host_rvalid = r_host_rvalid;
  assign cpu_rdata   = ram_q;
  assign host_rdata  = ram_q;
  assign owner       = {w_host_gnt, w_cpu_gnt};

endmodule
`default_nettype wire

// File: tb/tb_data_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_ram_arbiter
// Brief    : Self-checking bench for data_ram_arbiter: directed sequences
//            followed by constrained-random traffic, compared every cycle
//            against a transaction-level reference model with a shadow RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_ram_arbiter;

  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 8;
  localparam int MAX_WAIT  = 4;
  localparam int DEPTH     = 1 << ADDR_W;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              host_req, host_we, host_lock, host_gnt, host_rvalid;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata, host_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_en;
  logic [DATA_W-1:0] ram_q;
  logic [1:0]        owner;

  always #5 clk = ~clk;

  data_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_lock(host_lock),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_en(ram_en), .ram_q(ram_q),
    .owner(owner)
  );

  // Behavioural single-port RAM with registered read data.
  logic              preload = 1'b1;
  logic [DATA_W-1:0] ram_mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= DATA_W'(i * 37 + 5);
    end else begin
      if (ram_en) ram_mem[ram_addr] <= ram_data;
      ram_q <= ram_mem[ram_addr];
    end
  end

  // Reference model state (transaction level).
  bit                m_burst, m_yield;
  int                m_beats, m_waited;
  logic [DATA_W-1:0] shadow [0:DEPTH-1];
  bit                exp_cpu_rv, exp_host_rv;
  logic [DATA_W-1:0] exp_cpu_rd, exp_host_rd;
  bit                eg_cpu, eg_host;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: predict and check outputs mid-cycle, then advance the model.
  task automatic cycle();
    logic              en_e;
    logic [ADDR_W-1:0] a_e;
    logic [DATA_W-1:0] d_e;
    bit                idle;
    #1;
    eg_cpu  = 1'b0;
    eg_host = 1'b0;
    if (reset) begin
      if (m_yield)      eg_cpu  = cpu_req;
      else if (m_burst) eg_host = host_req;
      else if (cpu_req && !(GUARD && host_req && m_waited >= MAX_WAIT)) eg_cpu = 1'b1;
      else              eg_host = host_req;
    end
    en_e = eg_cpu ? cpu_we : (eg_host ? host_we : 1'b0);
    a_e  = eg_host ? host_addr : cpu_addr;
    d_e  = eg_cpu ? cpu_wdata : (eg_host ? host_wdata : '0);
    check("cpu_gnt", cpu_gnt, eg_cpu);
    check("host_gnt", host_gnt, eg_host);
    check("owner", owner, eg_host ? 2 : (eg_cpu ? 1 : 0));
    check("ram_en", ram_en, en_e);
    check("ram_addr", ram_addr, a_e);
    check("ram_data", ram_data, d_e);
    check("cpu_rvalid", cpu_rvalid, exp_cpu_rv);
    check("host_rvalid", host_rvalid, exp_host_rv);
    if (exp_cpu_rv)  check("cpu_rdata", cpu_rdata, exp_cpu_rd);
    if (exp_host_rv) check("host_rdata", host_rdata, exp_host_rd);

    @(posedge clk);
    if (!reset) begin
      m_burst = 0; m_yield = 0; m_beats = 0; m_waited = 0;
      exp_cpu_rv = 0; exp_host_rv = 0;
    end else begin
      exp_cpu_rv  = eg_cpu && !cpu_we;
      exp_host_rv = eg_host && !host_we;
      if (exp_cpu_rv)  exp_cpu_rd  = shadow[cpu_addr];
      if (exp_host_rv) exp_host_rd = shadow[host_addr];
      if (eg_cpu && cpu_we)   shadow[cpu_addr]  = cpu_wdata;
      if (eg_host && host_we) shadow[host_addr] = host_wdata;
      idle = !m_burst && !m_yield;
      if (eg_host || !host_req)               m_waited = 0;
      else if (idle && m_waited < MAX_WAIT)   m_waited++;
      if (m_yield) begin
        m_yield = 0; m_beats = 0;
      end else if (m_burst) begin
        if (!host_lock) begin
          m_burst = 0; m_beats = 0;
        end else if (eg_host) begin
          m_beats++;
          if (m_beats >= MAX_BURST) begin m_burst = 0; m_yield = 1; end
        end
      end else if (eg_host && host_lock) begin
        m_beats = 1;
        if (MAX_BURST == 1) m_yield = 1; else m_burst = 1;
      end
    end
    #1;
  endtask

  // Stimulus: directed sequences, then constrained-random traffic.
  initial begin
    int  idx;
    int  acc;
    bit  cpu_pend, host_pend;
    for (int i = 0; i < DEPTH; i++) shadow[i] = DATA_W'(i * 37 + 5);
    reset = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1; host_we = 0; host_lock = 0; host_addr = '0; host_wdata = '0;
    @(posedge clk);
    #1 preload = 1'b0;

    // Reset held with both requesters active, then release.
    repeat (3) cycle();
    reset = 1;
    cycle();

    // CPU write 0x5A to 0x20, read it back, then idle to see the data.
    host_req = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 7'h20; cpu_wdata = 8'h5A; cycle();
    cpu_we = 0; cycle();
    cpu_req = 0; cycle();

    // Contention: both requesting for 4 cycles, then CPU drops.
    cpu_req = 1; host_req = 1; host_we = 0; host_addr = 7'h20;
    repeat (4) cycle();
    cpu_req = 0; cycle();
    host_req = 0; cycle();

    // Locked host burst of 10 writes; CPU presses while host owns the RAM.
    idx = 0;
    host_req = 1; host_lock = 1; host_we = 1; cpu_we = 0; cpu_addr = 7'h40;
    for (int n = 0; n < 60 && idx < 10; n++) begin
      cpu_req    = m_burst || m_yield;
      host_addr  = ADDR_W'(16 + idx);
      host_wdata = DATA_W'(idx);
      cycle();
      if (eg_host) idx++;
    end
    check("burst_writes_done", idx, 10);
    host_lock = 0; host_req = 0; cpu_req = 0; cycle();

    // Read back the burst region through the host port.
    host_we = 0; host_req = 1;
    for (int k = 0; k < 10; k++) begin
      host_addr = ADDR_W'(16 + k);
      cycle();
    end
    host_req = 0; cycle();

    // Reset in the middle of a locked read burst.
    acc = 0;
    host_req = 1; host_lock = 1; host_we = 0;
    for (int n = 0; n < 20 && acc < 3; n++) begin
      host_addr = ADDR_W'(16 + acc);
      cycle();
      if (eg_host) acc++;
    end
    check("midburst_reads_done", acc, 3);
    reset = 0; cycle();
    reset = 1; host_we = 1;
    for (int n = 0; n < 12; n++) begin
      cpu_req    = (n > 0);
      host_addr  = ADDR_W'(48 + n);
      host_wdata = DATA_W'(8'hC0 + n);
      cycle();
    end
    cpu_req = 0; host_req = 0; host_lock = 0; cycle();

    // Constrained-random traffic honouring the hold-while-waiting rule.
    cpu_pend = 0; host_pend = 0;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 63) != 0);
      if (!cpu_pend) begin
        cpu_req   = $urandom_range(0, 1);
        cpu_we    = $urandom_range(0, 1);
        cpu_addr  = ADDR_W'($urandom_range(0, 15));
        cpu_wdata = DATA_W'($urandom);
      end
      if (!host_pend) begin
        host_req   = ($urandom_range(0, 2) != 0);
        host_we    = $urandom_range(0, 1);
        host_addr  = ADDR_W'($urandom_range(0, 15));
        host_wdata = DATA_W'($urandom);
      end
      host_lock = ($urandom_range(0, 7) != 0);
      cycle();
      cpu_pend  = reset && cpu_req && !eg_cpu;
      host_pend = reset && host_req && !eg_host;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Shares the single-port 128x8 data RAM between two requesters: the CPU controller (execute-state RAM accesses) and a host/debug port.
- Host uses: program load, register inspection, DMA fill.
- Sits between both requesters and the RAM instance, and drives the RAM address, data and write-enable pins.
- Policy: CPU has fixed priority. Host may lock the RAM for bounded bursts. An optional starvation guard limits how long the host can be blocked.

Parameters:
ADDR_W, 7, RAM address width (128 locations)
DATA_W, 8, RAM data width
MAX_BURST, 8, max host transactions per locked burst before forced yield
MAX_WAIT, 4, consecutive blocked host cycles before forced host grant (optional feature only)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low; reset==0 at a rising edge resets the block
cpu_req  input  1  CPU requests one RAM access this cycle
cpu_we  input  1  1=write, 0=read
cpu_addr  input  ADDR_W  CPU address
cpu_wdata  input  DATA_W  CPU write data
cpu_gnt  output  1  CPU access accepted at the next edge
cpu_rvalid  output  1  cpu_rdata valid (read accepted previous edge)
cpu_rdata  output  DATA_W  read data to CPU
host_req  input  1  host requests one access
host_we  input  1  1=write, 0=read
host_lock  input  1  host requests exclusive burst ownership
host_addr  input  ADDR_W  host address
host_wdata  input  DATA_W  host write data
host_gnt  output  1  host access accepted at the next edge
host_rvalid  output  1  host_rdata valid
host_rdata  output  DATA_W  read data to host
ram_addr  output  ADDR_W  to RAM addr
ram_data  output  DATA_W  to RAM data
ram_en  output  1  to RAM write enable
ram_q  input  DATA_W  RAM registered read data
owner  output  2  0=none, 1=CPU, 2=host granted this cycle

Behaviour:
- Reset:
  - FSM state = IDLE; burst_cnt = wait_cnt = 0.
  - cpu_rvalid = host_rvalid = 0.
  - While reset==0: gnt outputs, ram_en and owner are forced to 0.
- Handshake:
  - gnt is combinational from state, req and counters.
  - A transaction is accepted on the edge where req & gnt.
  - At most one gnt is high per cycle.
  - Requesters hold addr/we/wdata stable while req is high and gnt is low.
- RAM mux:
  - ram_addr/ram_data come from the granted port.
  - ram_en = granted port's we.
  - No grant: ram_en = 0, ram_addr = cpu_addr, ram_data = 0.
- Read latency: 1 cycle.
  - x_rvalid is registered: 1 in the cycle after an accepted read by port x, otherwise 0.
  - x_rdata = ram_q (pass-through); valid only while x_rvalid.
- FSM:
  - IDLE:
    - cpu_req -> cpu_gnt.
    - Else host_req -> host_gnt.
    - If host is accepted with host_lock=1 -> BURST, burst_cnt = 1.
  - BURST:
    - cpu_gnt = 0; host_gnt = host_req.
    - Each accepted host transaction increments burst_cnt.
    - host_lock=0 sampled at an edge -> IDLE, burst_cnt = 0.
    - Accept making burst_cnt == MAX_BURST -> YIELD.
  - YIELD (exactly 1 cycle):
    - cpu_gnt = cpu_req; host_gnt = 0.
    - Next state IDLE; burst_cnt = 0.
    - Host may re-lock from IDLE afterwards.
- Boundary cases:
  - Simultaneous cpu_req & host_req in IDLE: CPU wins (unless forced by the optional feature).
  - host_lock without host_req in IDLE: no effect.
  - host_req dropped in BURST while host_lock=1: stays in BURST; CPU remains blocked.
  - Reset mid-burst or with a read outstanding: IDLE, no rvalid for the in-flight read.
- owner reflects the current-cycle grant: 1 if cpu_gnt, 2 if host_gnt, else 0.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - wait_cnt increments in IDLE each cycle host_req=1 and host_gnt=0, saturating at MAX_WAIT.
  - When wait_cnt == MAX_WAIT, host wins the next IDLE arbitration over CPU (cpu_gnt=0).
  - wait_cnt clears on any host accept or when host_req=0.
  - Not counted in BURST/YIELD.
- Undefined: no wait_cnt; pure CPU priority; host may starve indefinitely.

Test Plan:
- Reset: hold reset=0 for 3 cycles with both req=1 -> gnts=0, ram_en=0, rvalids=0, owner=0; release -> CPU granted first cycle.
- Write then read: CPU writes 0x5A to addr 0x20, then reads 0x20 -> ram_en=1 for one cycle; cpu_rvalid=1 next cycle with cpu_rdata=0x5A; host_rvalid stays 0.
- Contention: cpu_req and host_req both held 4 cycles (guard undefined) -> cpu_gnt=1 all 4 cycles, host_gnt=0; host granted on the first cycle cpu_req=0.
- Burst: MAX_BURST=8, host_lock=1, host writes 0x00..0x09 to addr 0x10..0x19 with cpu_req=1 -> 8 host accepts, one YIELD cycle with cpu_gnt=1, then host resumes for remaining 2; RAM 0x10..0x19 = 0x00..0x09.
- Starvation (ARB_STARVE_GUARD_EN, MAX_WAIT=4): cpu_req and host_req held constantly -> 4 cycles cpu_gnt, 1 cycle host_gnt with owner=2, pattern repeats.
- Reset mid-burst: reset=0 after 3 accepted host reads in BURST -> state IDLE, host_rvalid=0 next cycle, burst_cnt restarts at 1 on next lock.
